// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with runtime line format (5..DATA_WIDTH data bits, parity,
// 1/2 stop bits, per-bit clock divisor) and break generation, fed from a small FIFO.
module uart_tx_cfg #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         tdata,
  input  logic                          tvalid,
  output logic                          tready,
  input  logic [3:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic [PRESCALE_WIDTH-1:0]     cfg_prescale,
  input  logic                          cfg_break,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = PRESCALE_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5,
    S_GUARD  = 3'd6
  } state_e;

  function automatic logic [3:0] clamp_bits_f(input logic [3:0] n);
    logic [3:0] r;
    if (n < 4'd5) begin
      r = 4'd5;
    end else if (n > 4'(DATA_WIDTH)) begin
      r = 4'(DATA_WIDTH);
    end else begin
      r = n;
    end
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mask_f(input logic [3:0] n);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

  function automatic logic parity_f(input logic [DATA_WIDTH-1:0] d, input logic [1:0] mode);
    logic p;
    case (mode)
      2'b01:   p = ^d;
      2'b10:   p = ~(^d);
      2'b11:   p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  // FIFO storage and control
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         count_q, count_d;
  logic                  tready_q, tready_d;
  logic                  push_s, pop_s, load_s;

  // Transmit engine
  state_e                state_q, state_d;
  logic [PW-1:0]         cnt_q, cnt_d, reload_q, reload_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [3:0]            bits_left_q, bits_left_d;
  logic                  has_par_q, has_par_d, par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d, stop_left_q, stop_left_d;
  logic                  txd_q, txd_d, busy_q, busy_d;
  logic                  bit_end_s;
  logic [PW-1:0]         cnt_step_s, pm1_cfg_s;
  logic [3:0]            nbits_s;
  logic [DATA_WIDTH-1:0] head_s, masked_s;

  assign head_s    = mem_q[rd_ptr_q];
  assign nbits_s   = clamp_bits_f(cfg_data_bits);
  assign masked_s  = head_s & mask_f(nbits_s);
  assign pm1_cfg_s = (cfg_prescale == {PW{1'b0}}) ? {PW{1'b0}} : cfg_prescale - PW'(1);

  // FIFO pointer/count next-state; tready is registered from the next count
  always_comb begin
    push_s   = tvalid & tready_q;
    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
    tready_d = (count_d != LW'(FIFO_DEPTH));
  end

  // FIFO payload write; contents need no reset since the pointers gate validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= tdata;
    end
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {LW{1'b0}};
      tready_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tready_q <= tready_d;
    end
  end

  // Frame sequencer: bit timing, shifting and frame/break transitions
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reload_d    = reload_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    has_par_d   = has_par_q;
    par_bit_d   = par_bit_q;
    stop2_d     = stop2_q;
    stop_left_d = stop_left_q;
    txd_d       = txd_q;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    bit_end_s   = (cnt_q == {PW{1'b0}});
    cnt_step_s  = bit_end_s ? reload_q : cnt_q - PW'(1);

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (cfg_break) begin
          state_d = S_BREAK;
          txd_d   = 1'b0;
        end else if (count_q != {LW{1'b0}}) begin
          load_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        cnt_d = cnt_step_s;
        if (bit_end_s) begin
          state_d     = S_DATA;
          txd_d       = shreg_q[0];
          shreg_d     = {1'b0, shreg_q[DATA_WIDTH-1:1]};
          bits_left_d = bits_left_q - 4'd1;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        cnt_d = cnt_step_s;
        if (!bit_end_s) begin
          state_d = S_DATA;
        end else if (bits_left_q != 4'd0) begin
          txd_d       = shreg_q[0];
          shreg_d     = {1'b0, shreg_q[DATA_WIDTH-1:1]};
          bits_left_d = bits_left_q - 4'd1;
        end else if (has_par_q) begin
          state_d = S_PARITY;
          txd_d   = par_bit_q;
        end else begin
          state_d     = S_STOP;
          txd_d       = 1'b1;
          stop_left_d = stop2_q;
        end
      end
      S_PARITY: begin
        cnt_d = cnt_step_s;
        if (bit_end_s) begin
          state_d     = S_STOP;
          txd_d       = 1'b1;
          stop_left_d = stop2_q;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        cnt_d = cnt_step_s;
        if (!bit_end_s) begin
          state_d = S_STOP;
        end else if (stop_left_q) begin
          stop_left_d = 1'b0;
        end else if ((count_q != {LW{1'b0}}) && !cfg_break) begin
          load_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BREAK: begin
        if (!cfg_break) begin
          state_d  = S_GUARD;
          txd_d    = 1'b1;
          reload_d = pm1_cfg_s;
          cnt_d    = pm1_cfg_s;
        end else begin
          txd_d = 1'b0;
        end
      end
      S_GUARD: begin
        cnt_d = cnt_step_s;
        if (bit_end_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GUARD;
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Frame start: everything about the line format is captured here and held
    if (load_s) begin
      pop_s       = 1'b1;
      state_d     = S_START;
      txd_d       = 1'b0;
      reload_d    = pm1_cfg_s;
      cnt_d       = pm1_cfg_s;
      shreg_d     = masked_s;
      bits_left_d = nbits_s;
      has_par_d   = (cfg_parity != 2'b00);
      par_bit_d   = parity_f(masked_s, cfg_parity);
      stop2_d     = cfg_stop2;
      stop_left_d = 1'b0;
    end else begin
      pop_s = 1'b0;
    end
  end

  // busy reflects the state and occupancy that will hold after this edge
  always_comb begin
    busy_d = (state_d != S_IDLE) || (count_d != {LW{1'b0}});
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= {PW{1'b0}};
      reload_q    <= {PW{1'b0}};
      shreg_q     <= {DATA_WIDTH{1'b0}};
      bits_left_q <= 4'd0;
      has_par_q   <= 1'b0;
      par_bit_q   <= 1'b0;
      stop2_q     <= 1'b0;
      stop_left_q <= 1'b0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reload_q    <= reload_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      has_par_q   <= has_par_d;
      par_bit_q   <= par_bit_d;
      stop2_q     <= stop2_d;
      stop_left_q <= stop_left_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
    end
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign tready     = tready_q;
  assign fifo_level = count_q;

endmodule
